// File: rtl/serial_xor_pkg.sv
// Shared types and defaults for the serial XOR sequencer.
package serial_xor_pkg;

   localparam int SXS_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sxs_state_t;

   // Bit counter width able to hold every value 0..width
   function automatic int sxs_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/sxs_bit_counter.sv
// Bit-position counter for the serial XOR sequencer; o_last flags the final bit (WIDTH-1).
module sxs_bit_counter
   import serial_xor_pkg::*;
#(
   parameter int WIDTH = SXS_DEFAULT_WIDTH
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_last
);

   localparam int CW = sxs_cnt_width(WIDTH);

   logic [CW-1:0] r_cnt;

   // Counter register: clear on a new operation, step once per serial bit
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CW'(1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_xor_sequencer.sv
// Time-shares one external combinational Xor cell to XOR two WIDTH-bit operands, LSB first.
// Optional running parity output is enabled with the SXS_PARITY_EN macro.
module serial_xor_sequencer
   import serial_xor_pkg::*;
#(
   parameter int WIDTH = SXS_DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a_in,
   input  logic [WIDTH-1:0] i_b_in,
   output logic             o_xor_a,
   output logic             o_xor_b,
   input  logic             i_xor_res,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
`ifdef SXS_PARITY_EN
   ,
   output logic             o_parity
`endif
);

   sxs_state_t       r_state;
   sxs_state_t       w_state_next;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] w_result_next;
   logic             w_accept;
   logic             w_run;
   logic             w_last;

   assign w_accept = (r_state == IDLE) && i_start;
   assign w_run    = (r_state == RUN);

   // New bit from the shared cell enters at the MSB so the LSB-first stream lands in place
   assign w_result_next = (r_result >> 1) | (WIDTH'(i_xor_res) << (WIDTH - 1));

   sxs_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (w_accept),
      .i_en   (w_run),
      .o_last (w_last)
   );

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    w_state_next = i_start ? RUN : IDLE;
         RUN:     w_state_next = w_last ? DONE : RUN;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // FSM outputs; the Xor cell inputs are parked at zero outside RUN
   always_comb begin
      o_busy  = 1'b0;
      o_done  = 1'b0;
      o_xor_a = 1'b0;
      o_xor_b = 1'b0;
      case (r_state)
         RUN: begin
            o_busy  = 1'b1;
            o_xor_a = r_opa[0];
            o_xor_b = r_opb[0];
         end
         DONE: begin
            o_done = 1'b1;
         end
         default: begin
            o_busy = 1'b0;
         end
      endcase
   end

   // Operand shift registers and result assembly
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_opa    <= '0;
         r_opb    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_opa    <= i_a_in;
         r_opb    <= i_b_in;
         r_result <= '0;
      end else if (w_run) begin
         r_opa    <= r_opa >> 1;
         r_opb    <= r_opb >> 1;
         r_result <= w_result_next;
      end else begin
         r_opa    <= r_opa;
         r_opb    <= r_opb;
         r_result <= r_result;
      end
   end

   assign o_result = r_result;

`ifdef SXS_PARITY_EN
   logic r_parity;

   // Running parity of the bits returned by the Xor cell
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_parity <= 1'b0;
      end else if (w_accept) begin
         r_parity <= 1'b0;
      end else if (w_run) begin
         r_parity <= r_parity ^ i_xor_res;
      end else begin
         r_parity <= r_parity;
      end
   end

   assign o_parity = r_parity;
`endif

endmodule

// File: tb/tb_serial_xor_sequencer.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 sequencers, each with its own shared Xor cell.
module tb_serial_xor_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start8 = 1'b0;
   logic [7:0] a8 = 8'h00;
   logic [7:0] b8 = 8'h00;
   logic       xa8, xb8, xr8, busy8, done8, par8;
   logic [7:0] res8;

   logic       start1 = 1'b0;
   logic [0:0] a1 = 1'b0;
   logic [0:0] b1 = 1'b0;
   logic       xa1, xb1, xr1, busy1, done1, par1;
   logic [0:0] res1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // The shared Xor cells live outside the sequencers
   assign xr8 = xa8 ^ xb8;
   assign xr1 = xa1 ^ xb1;

   serial_xor_sequencer #(.WIDTH(8)) u_dut8 (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start8),
      .i_a_in    (a8),
      .i_b_in    (b8),
      .o_xor_a   (xa8),
      .o_xor_b   (xb8),
      .i_xor_res (xr8),
      .o_busy    (busy8),
      .o_done    (done8),
      .o_result  (res8)
`ifdef SXS_PARITY_EN
      ,
      .o_parity  (par8)
`endif
   );

   serial_xor_sequencer #(.WIDTH(1)) u_dut1 (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start1),
      .i_a_in    (a1),
      .i_b_in    (b1),
      .o_xor_a   (xa1),
      .o_xor_b   (xb1),
      .i_xor_res (xr1),
      .o_busy    (busy1),
      .o_done    (done1),
      .o_result  (res1)
`ifdef SXS_PARITY_EN
      ,
      .o_parity  (par1)
`endif
   );

`ifndef SXS_PARITY_EN
   assign par8 = 1'b0;
   assign par1 = 1'b0;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] exp_res;
      logic       exp_par;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One WIDTH=8 operation observed for 14 cycles; optional start glitch or reset injection
   task automatic run8(input logic [7:0] a, input logic [7:0] b,
                       input int glitch_cyc, input logic [7:0] ga, input logic [7:0] gb,
                       input int rst_cyc,
                       output int busy_n, output int done_n, output int done_cyc,
                       output logic [7:0] res, output logic par, output int xbit_err,
                       output logic [7:0] res_rst, output logic busy_rst);
      busy_n = 0; done_n = 0; done_cyc = -1; res = 8'h00; par = 1'b0; xbit_err = 0;
      res_rst = 8'hFF; busy_rst = 1'b1;
      a8 = a; b8 = b; start8 = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (busy8) begin
            busy_n++;
            if (c > 8) xbit_err++;
            else if (xa8 !== a[c-1] || xb8 !== b[c-1]) xbit_err++;
         end else if (xa8 !== 1'b0 || xb8 !== 1'b0) begin
            xbit_err++;
         end
         if (done8) begin
            done_n++;
            if (done_cyc < 0) begin
               done_cyc = c; res = res8; par = par8;
            end
         end
         start8 = (c == glitch_cyc);
         if (c == glitch_cyc) begin
            a8 = ga; b8 = gb;
         end
         if (c == rst_cyc + 1) begin
            res_rst = res8; busy_rst = busy8; rst = 1'b0;
         end
         if (c == rst_cyc) rst = 1'b1;
      end
   endtask

   vec_t vecs[4];
   int   busy_n, done_n, done_cyc, xbit_err;
   logic [7:0] res, res_rst;
   logic par, busy_rst;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy8", 32'(busy8), 32'd0);
      check("rst_done8", 32'(done8), 32'd0);
      check("rst_result8", 32'(res8), 32'd0);
      check("rst_xor_ab8", {30'd0, xa8, xb8}, 32'd0);
      check("rst_parity8", 32'(par8), 32'd0);
      check("rst_result1", 32'(res1), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors
      vecs[0] = '{8'hA5, 8'h0F, 8'hAA, 1'b0};
      vecs[1] = '{8'h3C, 8'h3C, 8'h00, 1'b0};
      vecs[2] = '{8'h01, 8'h00, 8'h01, 1'b1};
      vecs[3] = '{8'hFF, 8'h80, 8'h7F, 1'b1};
      for (int i = 0; i < 4; i++) begin
         run8(vecs[i].a, vecs[i].b, -5, 8'h00, 8'h00, -5,
              busy_n, done_n, done_cyc, res, par, xbit_err, res_rst, busy_rst);
         check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'd8);
         check($sformatf("vec%0d_done_cycle", i), 32'(done_cyc), 32'd9);
         check($sformatf("vec%0d_done_pulses", i), 32'(done_n), 32'd1);
         check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
         check($sformatf("vec%0d_xor_bits", i), 32'(xbit_err), 32'd0);
         check($sformatf("vec%0d_result_held", i), 32'(res8), 32'(vecs[i].exp_res));
`ifdef SXS_PARITY_EN
         check($sformatf("vec%0d_parity", i), 32'(par), 32'(vecs[i].exp_par));
`endif
      end

      // Random operands against the reference: result = a ^ b, parity = xor-reduce
      for (int i = 0; i < 12; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         run8(ra, rb, -5, 8'h00, 8'h00, -5,
              busy_n, done_n, done_cyc, res, par, xbit_err, res_rst, busy_rst);
         check($sformatf("rnd%0d_result", i), 32'(res), 32'(ra ^ rb));
         check($sformatf("rnd%0d_timing", i), {busy_n[15:0], done_cyc[15:0]}, {16'd8, 16'd9});
`ifdef SXS_PARITY_EN
         check($sformatf("rnd%0d_parity", i), 32'(par), 32'(^(ra ^ rb)));
`endif
      end

      // Start during RUN is ignored
      run8(8'hA5, 8'h0F, 3, 8'hFF, 8'hFF, -5,
           busy_n, done_n, done_cyc, res, par, xbit_err, res_rst, busy_rst);
      check("busy_start_result", 32'(res), 32'hAA);
      check("busy_start_pulses", 32'(done_n), 32'd1);
      check("busy_start_busy", 32'(busy_n), 32'd8);

      // Reset in RUN cycle 4 aborts without done
      run8(8'hA5, 8'h0F, -5, 8'h00, 8'h00, 4,
           busy_n, done_n, done_cyc, res, par, xbit_err, res_rst, busy_rst);
      check("rst_mid_busy", 32'(busy_rst), 32'd0);
      check("rst_mid_result", 32'(res_rst), 32'd0);
      check("rst_mid_no_done", 32'(done_n), 32'd0);
      check("rst_mid_busy_cycles", 32'(busy_n), 32'd4);

      // WIDTH=1: RUN for one cycle, done in cycle 2
      for (int k = 0; k < 2; k++) begin
         int b1n, d1c;
         logic [0:0] r1;
         b1n = 0; d1c = -1; r1 = 1'b0;
         a1 = 1'b1; b1 = 1'(k); start1 = 1'b1;
         for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (busy1) b1n++;
            if (done1 && d1c < 0) begin
               d1c = c; r1 = res1;
            end
         end
         check($sformatf("w1_%0d_busy", k), 32'(b1n), 32'd1);
         check($sformatf("w1_%0d_done_cycle", k), 32'(d1c), 32'd2);
         check($sformatf("w1_%0d_result", k), 32'(r1), 32'(1'b1 ^ 1'(k)));
      end

      // Back-to-back with start held: accepts every 10 cycles, operands at acceptance
      begin
         logic [7:0] av[32], bv[32];
         int pattern_err, pulses;
         pattern_err = 0; pulses = 0;
         start8 = 1'b1;
         for (int t = 0; t < 32; t++) begin
            av[t] = 8'($urandom_range(0, 255));
            bv[t] = 8'($urandom_range(0, 255));
            a8 = av[t]; b8 = bv[t];
            @(negedge clk);
            if (done8 !== (((t + 1) % 10) == 9)) pattern_err++;
            if (((t + 1) % 10) == 9) begin
               pulses++;
               check($sformatf("b2b_result%0d", pulses), 32'(res8),
                     32'(av[t - 8] ^ bv[t - 8]));
            end
         end
         start8 = 1'b0;
         check("b2b_done_pattern", 32'(pattern_err), 32'd0);
         repeat (12) @(negedge clk);
         check("b2b_idle_after", {30'd0, busy8, done8}, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_xor_sequencer.md
# serial_xor_sequencer

Sequencer that time-shares a single external one-bit `Xor` cell to compute the bitwise XOR of two N-bit operands, one bit per clock, LSB first. It latches the operands on `start` and presents each bit pair to the shared cell. It then shifts the cell's result back into an N-bit result register and pulses `done`. It sits between the operand/control logic and the gate-level `Xor` instance, which it drives through `xor_a`/`xor_b` and samples through `xor_res`.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values are 1 to 32.
- `clk` input, 1 bit: the single clock, rising-edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: request to begin; sampled only in IDLE.
- `a_in` input, WIDTH bits: operand A; sampled on an accepted `start`.
- `b_in` input, WIDTH bits: operand B; sampled on an accepted `start`.
- `xor_a` output, 1 bit: bit to the shared Xor input `a`.
- `xor_b` output, 1 bit: bit to the shared Xor input `b`.
- `xor_res` input, 1 bit: combinational output of the shared Xor.
- `busy` output, 1 bit: high while in RUN.
- `done` output, 1 bit: one-cycle pulse when the result is complete.
- `result` output, WIDTH bits: assembled XOR result; holds its value until the next accepted `start`.
- `parity` output, 1 bit: XOR-reduction of `result`; present only with `SXS_PARITY_EN`.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- In IDLE with `start`=1:
  - Load `a_in`/`b_in` into the operand shift registers `opa`/`opb`.
  - Clear `result` and the bit counter `cnt` (`$clog2(WIDTH+1)` bits).
  - Go to RUN.
- In RUN:
  - `xor_a`=`opa[0]` and `xor_b`=`opb[0]`, driven combinationally from registers.
  - Each cycle: `result` <= {`xor_res`, `result[WIDTH-1:1]`}, `opa`/`opb` shift right by 1 with zero fill, and `cnt` increments.
  - When `cnt`==WIDTH-1 in the current cycle, the last bit is captured and the next state is DONE.
- In DONE: `done`=1 for exactly one cycle, then return to IDLE unconditionally.
- `start` in RUN or DONE is ignored, with no queuing. `start` held high in IDLE after DONE begins a new operation.
- Outside RUN, `xor_a`=`xor_b`=0.
- WIDTH=1: RUN lasts exactly one cycle.
- `rst` has priority over everything. It forces IDLE, clears `opa`, `opb`, `result`, `cnt` and the parity register, and aborts any operation in progress without asserting `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `xor_a`=0, `xor_b`=0, `parity`=0.
- `start` sampled at edge 0 gives RUN during cycles 1..WIDTH and `done` high in cycle WIDTH+1.
- Latency from `start` to `done` is WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
- `busy` is high for exactly WIDTH cycles per operation.
- `result` is final when `done` is high and stays stable until the cycle after the next accepted `start`.
- `xor_res` must settle within the same cycle, as the Xor cell is purely combinational.

## Configuration
- Macro: `SXS_PARITY_EN`.
- When defined:
  - A 1-bit register accumulates `parity` ^= `xor_res` on each RUN cycle.
  - It is cleared on an accepted `start`.
  - `parity` is valid with `done` and held afterwards.
- When undefined: the `parity` port and its register are absent, and all other behaviour is identical.

## Structure
- Package `serial_xor_pkg` holds:
  - The state enum `sxs_state_t` {IDLE, RUN, DONE}.
  - Localparam `SXS_DEFAULT_WIDTH`=8.
- One natural sub-module is `sxs_bit_counter`: a WIDTH-aware counter with synchronous clear and a `last` flag.
- The shared `Xor` instance stays outside this block. The bench instantiates it alongside the sequencer.

## Test plan
- Basic operation: WIDTH=8, `a_in`=8'hA5, `b_in`=8'h0F, pulse `start` -> `busy` high for 8 cycles, `done` in cycle 9, `result`=8'hAA, and `parity`=0 when `SXS_PARITY_EN` is defined.
- Equal operands: `a_in`=`b_in`=8'h3C -> `result`=8'h00, `parity`=0. Then `a_in`=8'h01, `b_in`=8'h00 -> `result`=8'h01, `parity`=1.
- Busy-start ignored: `start` re-asserted during RUN with different operands -> the first result (8'hAA) is unaffected and exactly one `done` pulse occurs.
- Reset mid-operation: `rst` asserted in RUN cycle 4 -> next cycle `busy`=0 and `result`=0, and no `done` pulse follows.
- Minimum width: WIDTH=1, `a_in`=1, `b_in`=0 -> `busy` for 1 cycle, `done` in cycle 2, `result`=1.
- Back-to-back: `start` held high continuously -> `done` pulses every WIDTH+2 cycles, and each pulse reflects the operands present at that acceptance.
